// File: rtl/link_pkg.sv
// Shared definitions for the 4-phase byte link: the arbiter state type, the default
// data width and the round-robin pick used when two masters contend for the slave.
package link_pkg;

    localparam int unsigned LinkDataW = 8;

    typedef enum logic {
        StIdle,
        StBusy
    } link_state_e;

    // Returns the id (0/1) to grant; only meaningful when at least one req bit is set.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_id);
        // On a tie the link goes to whichever master did not hold it last.
        if (req[0] && req[1]) begin
            return ~last_id;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/link_arbiter.sv
// Two-requester round-robin arbiter for a shared 4-phase req/ack byte link.
// Grants one complete handshake at a time, forwards req/data down and ack up,
// counts completed transfers per master and flags a slave that never acks.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m0_req/m0_data    master 0 request and data; m0_ack acknowledge back to master 0
//   m1_req/m1_data    master 1 request and data; m1_ack acknowledge back to master 1
//   link_req/data     request and data to the shared slave; link_ack from the slave
//   gnt               one-hot current owner, 00 when idle
//   cnt0, cnt1        completed transfers per master, wrapping at 8 bits
//   err               sticky timeout flag, cleared only by rst
module link_arbiter
    import link_pkg::*;
#(
    parameter int unsigned DATA_W    = LinkDataW,
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [DATA_W-1:0] m0_data,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic [DATA_W-1:0] m1_data,
    output logic              m1_ack,
    output logic              link_req,
    output logic [DATA_W-1:0] link_data,
    input  logic              link_ack,
    output logic [1:0]        gnt,
    output logic [7:0]        cnt0,
    output logic [7:0]        cnt1,
    output logic              err
);

    localparam logic [7:0] TimerLast = 8'(TO_CYCLES - 1);

    link_state_e state_q, state_d;
    logic        gnt_id_q, gnt_id_d;
    logic        last_id_q, last_id_d;
    logic        seen_ack_q, seen_ack_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  cnt0_q, cnt0_d;
    logic [7:0]  cnt1_q, cnt1_d;
    logic        err_q, err_d;

    logic [1:0]  req_v;
    logic        req_g;

    assign req_v = {m1_req, m0_req};
    assign req_g = req_v[gnt_id_q];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_id_q   <= 1'b0;
            last_id_q  <= 1'b1;  // master 0 wins the first tie
            seen_ack_q <= 1'b0;
            timer_q    <= 8'd0;
            cnt0_q     <= 8'd0;
            cnt1_q     <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            last_id_q  <= last_id_d;
            seen_ack_q <= seen_ack_d;
            timer_q    <= timer_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        last_id_d  = last_id_q;
        seen_ack_d = seen_ack_q;
        timer_d    = timer_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (|req_v) begin
                    state_d    = StBusy;
                    gnt_id_d   = rr_pick(req_v, last_id_q);
                    seen_ack_d = 1'b0;
                    timer_d    = 8'd0;
                end
            end
            StBusy: begin
                if (link_ack) begin
                    seen_ack_d = 1'b1;
                end else if (!req_g) begin
                    // Req low with ack low: completion if the slave acked, else an abort.
                    state_d   = StIdle;
                    last_id_d = gnt_id_q;
                    if (seen_ack_q) begin
                        if (gnt_id_q) begin
                            cnt1_d = cnt1_q + 8'd1;
                        end else begin
                            cnt0_d = cnt0_q + 8'd1;
                        end
                    end
                end else if (!seen_ack_q) begin
                    if (timer_q == TimerLast) begin
                        state_d   = StIdle;
                        last_id_d = gnt_id_q;
                        err_d     = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: the granted master is wired straight through to the link
    always_comb begin
        gnt       = 2'b00;
        link_req  = 1'b0;
        link_data = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        if (state_q == StBusy) begin
            gnt       = gnt_id_q ? 2'b10 : 2'b01;
            link_req  = req_g;
            link_data = gnt_id_q ? m1_data : m0_data;
            m0_ack    = link_ack & ~gnt_id_q;
            m1_ack    = link_ack & gnt_id_q;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
    assign err  = err_q;

endmodule

// File: tb/tb_link_arbiter.sv
module tb_link_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_v = 2'b00;
    logic [DW-1:0] data_v [2];
    logic          link_ack = 1'b0;
    logic          m0_ack, m1_ack, link_req, err;
    logic [DW-1:0] link_data;
    logic [1:0]    gnt;
    logic [7:0]    cnt0, cnt1;

    always #5 clk = ~clk;

    link_arbiter #(
        .DATA_W   (DW),
        .TO_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (req_v[0]),
        .m0_data  (data_v[0]),
        .m0_ack   (m0_ack),
        .m1_req   (req_v[1]),
        .m1_data  (data_v[1]),
        .m1_ack   (m1_ack),
        .link_req (link_req),
        .link_data(link_data),
        .link_ack (link_ack),
        .gnt      (gnt),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .err      (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the link, whether the slave has acked this handshake,
    // how many busy cycles have passed without an ack, and the spec-level counters.
    int mo_own = -1;
    bit mo_acked = 0;
    int mo_wait = 0;
    int mo_last = 1;
    int mo_cnt [2] = '{0, 0};
    bit mo_err = 0;

    // Bench-side masters and slave
    bit         agents_on = 0;
    int         ag_st [2] = '{0, 0};  // 0 idle, 1 requesting, 2 waiting for ack to drop
    int         ag_left [2] = '{0, 0};
    int         ag_pct = 100;
    int         ag_abort = 0;
    bit         fixed_en = 0;
    logic [7:0] fixed_d [2];
    int         sl_fixed = 0;
    int         sl_cnt = 0;
    logic [1:0] s_ack;
    logic       s_lreq;

    // Observed grant history
    int         gq [$];
    logic [7:0] dq [$];
    int         gapq [$];
    int         idle_run = 0;
    logic [1:0] prev_gnt = 2'b00;

    function automatic int sl_delay();
        if (sl_fixed >= 0) return sl_fixed;
        if ($urandom_range(9) == 0) return 1000;
        return int'($urandom_range(3));
    endfunction

    task automatic drive_agents();
        for (int i = 0; i < 2; i++) begin
            case (ag_st[i])
                0: if (ag_left[i] > 0 && int'($urandom_range(99)) < ag_pct) begin
                    req_v[i]  = 1'b1;
                    data_v[i] = fixed_en ? fixed_d[i] : 8'($urandom);
                    ag_left[i]--;
                    ag_st[i] = 1;
                end
                1: if (s_ack[i]) begin
                    req_v[i] = 1'b0;
                    ag_st[i] = 2;
                end else if (int'($urandom_range(99)) < ag_abort) begin
                    req_v[i] = 1'b0;
                    ag_st[i] = 0;
                end
                default: if (!s_ack[i]) ag_st[i] = 0;
            endcase
        end
        if (!s_lreq) begin
            link_ack = 1'b0;
            sl_cnt   = sl_delay();
        end else if (!link_ack) begin
            if (sl_cnt == 0) link_ack = 1'b1;
            else sl_cnt--;
        end
    endtask

    task automatic step();
        logic [1:0] e_gnt;
        logic       e_lreq;
        logic [7:0] e_ldata;
        logic [1:0] e_ack;
        @(negedge clk);
        e_gnt = 2'b00; e_lreq = 1'b0; e_ldata = 8'h00; e_ack = 2'b00;
        if (mo_own >= 0) begin
            e_gnt[mo_own] = 1'b1;
            e_lreq        = req_v[mo_own];
            e_ldata       = data_v[mo_own];
            e_ack[mo_own] = link_ack;
        end
        check_eq("gnt", gnt, e_gnt);
        check_eq("link_req", link_req, e_lreq);
        check_eq("link_data", link_data, e_ldata);
        check_eq("m0_ack", m0_ack, e_ack[0]);
        check_eq("m1_ack", m1_ack, e_ack[1]);
        check_eq("cnt0", cnt0, mo_cnt[0]);
        check_eq("cnt1", cnt1, mo_cnt[1]);
        check_eq("err", err, mo_err);

        if (gnt == 2'b00) begin
            idle_run++;
        end else if (prev_gnt == 2'b00) begin
            gq.push_back(gnt[1] ? 1 : 0);
            dq.push_back(link_data);
            gapq.push_back(idle_run);
            idle_run = 0;
        end
        prev_gnt = gnt;
        s_ack    = {m1_ack, m0_ack};
        s_lreq   = link_req;

        // Advance the model by one clock edge
        if (rst) begin
            mo_own = -1; mo_acked = 0; mo_wait = 0; mo_last = 1;
            mo_cnt = '{0, 0}; mo_err = 0;
        end else if (mo_own < 0) begin
            if (req_v == 2'b11) mo_own = 1 - mo_last;
            else if (req_v[0]) mo_own = 0;
            else if (req_v[1]) mo_own = 1;
            mo_acked = 0;
            mo_wait  = 0;
        end else if (link_ack) begin
            mo_acked = 1;
        end else if (!req_v[mo_own]) begin
            if (mo_acked) mo_cnt[mo_own] = (mo_cnt[mo_own] + 1) % 256;
            mo_last = mo_own;
            mo_own  = -1;
        end else if (!mo_acked) begin
            mo_wait++;
            if (mo_wait == TO) begin
                mo_err  = 1;
                mo_last = mo_own;
                mo_own  = -1;
            end
        end

        @(posedge clk);
        #1;
        if (agents_on) drive_agents();
    endtask

    task automatic do_reset();
        agents_on = 0;
        rst       = 1'b1;
        req_v     = 2'b00;
        data_v[0] = 8'h00;
        data_v[1] = 8'h00;
        link_ack  = 1'b0;
        ag_st     = '{0, 0};
        ag_left   = '{0, 0};
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic cfg(input int pct, input int abort_pct, input bit fix, input int slave);
        ag_pct   = pct;
        ag_abort = abort_pct;
        fixed_en = fix;
        sl_fixed = slave;
        gq.delete();
        dq.delete();
        gapq.delete();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        bit done = 0;
        agents_on = 1;
        while (!done && n < budget) begin
            step();
            n++;
            done = (ag_st[0] == 0 && ag_st[1] == 0 && ag_left[0] == 0 && ag_left[1] == 0 &&
                    mo_own < 0 && !link_ack);
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        data_v[0] = 8'h00;
        data_v[1] = 8'h00;
        do_reset();
        check_eq("rst_gnt", gnt, 2'b00);
        check_eq("rst_link_req", link_req, 1'b0);
        check_eq("rst_cnt0", cnt0, 8'd0);
        check_eq("rst_err", err, 1'b0);

        // Single requester, slave acks after 2 cycles
        cfg(100, 0, 1, 2);
        fixed_d[0] = 8'hA5;
        ag_left[0] = 1;
        run_until_idle("single", 60);
        check_eq("single_ngrants", gq.size(), 1);
        if (gq.size() >= 1) begin
            check_eq("single_gid", gq[0], 0);
            check_eq("single_data", dq[0], 8'hA5);
        end
        check_eq("single_cnt0", cnt0, 8'd1);
        check_eq("single_cnt1", cnt1, 8'd0);

        // Tie straight after reset: m0 first, one idle cycle, then m1
        do_reset();
        cfg(100, 0, 1, 1);
        fixed_d[0] = 8'h11;
        fixed_d[1] = 8'h22;
        ag_left    = '{1, 1};
        run_until_idle("tie", 80);
        check_eq("tie_ngrants", gq.size(), 2);
        if (gq.size() >= 2) begin
            check_eq("tie_first", gq[0], 0);
            check_eq("tie_second", gq[1], 1);
            check_eq("tie_data0", dq[0], 8'h11);
            check_eq("tie_data1", dq[1], 8'h22);
            check_eq("tie_gap", gapq[1], 1);
        end
        check_eq("tie_cnt0", cnt0, 8'd1);
        check_eq("tie_cnt1", cnt1, 8'd1);

        // Fairness: both keep requesting back to back
        cfg(100, 0, 0, 1);
        ag_left = '{3, 3};
        run_until_idle("fair", 200);
        check_eq("fair_ngrants", gq.size(), 6);
        for (int i = 0; i < gq.size() && i < 6; i++) check_eq("fair_order", gq[i], i % 2);
        check_eq("fair_cnt0", cnt0, 8'd4);
        check_eq("fair_cnt1", cnt1, 8'd4);

        // Timeout: slave never acks, m0 holds req for exactly the grant plus 4 busy cycles
        agents_on = 0;
        link_ack  = 1'b0;
        req_v[0]  = 1'b1;
        data_v[0] = 8'h5A;
        repeat (5) step();
        req_v[0] = 1'b0;
        check_eq("to_err", err, 1'b1);
        check_eq("to_gnt", gnt, 2'b00);
        check_eq("to_cnt0", cnt0, 8'd4);
        step();
        cfg(100, 0, 0, 1);
        ag_left = '{1, 1};
        run_until_idle("post_to", 100);
        check_eq("post_to_err", err, 1'b1);
        check_eq("post_to_cnt0", cnt0, 8'd5);
        check_eq("post_to_cnt1", cnt1, 8'd5);

        // Abort: m1 drops req before any ack
        agents_on = 0;
        req_v[1]  = 1'b1;
        data_v[1] = 8'h77;
        step();
        step();
        check_eq("abort_granted", gnt, 2'b10);
        req_v[1] = 1'b0;
        step();
        check_eq("abort_gnt", gnt, 2'b00);
        check_eq("abort_cnt1", cnt1, 8'd5);
        step();

        // Random traffic with aborts and occasional timeouts
        do_reset();
        cfg(30, 3, 0, -1);
        ag_left   = '{100000, 100000};
        agents_on = 1;
        repeat (3000) step();
        ag_left = '{0, 0};
        run_until_idle("random", 3000);

        // Wrap: 256 transfers on m0
        do_reset();
        cfg(100, 0, 0, 0);
        ag_left[0] = 256;
        run_until_idle("wrap", 5000);
        check_eq("wrap_ngrants", gq.size(), 256);
        check_eq("wrap_cnt0", cnt0, 8'd0);
        check_eq("wrap_cnt1", cnt1, 8'd0);

        // Reset mid-handshake while the slave is acking; last owner before reset was m0
        cfg(100, 0, 0, 0);
        ag_left[0] = 1;
        agents_on  = 1;
        for (int k = 0; k < 30 && !link_ack; k++) step();
        check_eq("rstmid_ack_seen", link_ack, 1'b1);
        agents_on = 0;
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_v[1]  = 1'b1;
        data_v[1] = 8'h3C;
        #1;
        check_eq("rstmid_link_req", link_req, 1'b0);
        check_eq("rstmid_m0_ack", m0_ack, 1'b0);
        check_eq("rstmid_m1_ack", m1_ack, 1'b0);
        check_eq("rstmid_gnt", gnt, 2'b00);
        check_eq("rstmid_cnt1", cnt1, 8'd0);
        step();
        check_eq("rstmid_tie_m0", gnt, 2'b01);
        ag_st   = '{1, 1};
        ag_left = '{0, 0};
        run_until_idle("post_rst", 200);
        check_eq("post_rst_cnt0", cnt0, 8'd1);
        check_eq("post_rst_cnt1", cnt1, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/link_arbiter.md
# link_arbiter

Two-requester round-robin arbiter that shares one 4-phase req/ack byte link between two masters. It sits between two master FSMs and a single slave FSM. It grants the link for exactly one complete handshake at a time and forwards req/data downstream and ack upstream. It also keeps per-requester transfer counts and flags a slave that never acknowledges.

## Interface
- DATA_W, 8, width of the link data bus
- TO_CYCLES, 255, maximum cycles in BUSY without link_ack before timeout (1..255)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- m0_req  input  1  requester 0 4-phase request
- m0_data  input  DATA_W  requester 0 data, stable while m0_req=1
- m0_ack  output  1  acknowledge to requester 0
- m1_req  input  1  requester 1 4-phase request
- m1_data  input  DATA_W  requester 1 data
- m1_ack  output  1  acknowledge to requester 1
- link_req  output  1  request to the shared slave
- link_data  output  DATA_W  data to the shared slave
- link_ack  input  1  acknowledge from the shared slave
- gnt  output  2  one-hot current grant, 00 when idle
- cnt0, cnt1  output  8  completed transfers per requester, wrap 255→0
- err  output  1  sticky timeout flag

## Operation
- States: IDLE, BUSY. Registers: state, gnt_id (0/1), last_id, seen_ack, timer (8b), cnt0, cnt1, err.
- IDLE:
  - If exactly one m*_req=1, grant that requester.
  - If both are 1, grant the requester ≠ last_id.
  - On grant: state→BUSY, gnt_id set, seen_ack←0, timer←0.
- BUSY outputs, combinational from registers:
  - link_req=m_req[gnt_id], link_data=m_data[gnt_id].
  - m_ack[gnt_id]=link_ack; the other ack stays 0.
- IDLE outputs: link_req=0, link_data=0, both acks 0, gnt=00.
- BUSY transitions, evaluated in priority order:
  1. Completion: if link_ack=1, seen_ack←1. When seen_ack=1 and m_req[gnt_id]=0 and link_ack=0: state→IDLE, last_id←gnt_id, cnt[gnt_id]+=1.
  2. Abort: m_req[gnt_id]=0 while seen_ack=0 and link_ack=0. State→IDLE, last_id←gnt_id, no count.
  3. Timeout: seen_ack=0 and timer reaches TO_CYCLES-1 without link_ack. State→IDLE, err←1, last_id←gnt_id, no count. Otherwise timer increments each BUSY cycle while seen_ack=0.
- A non-granted requester's req is ignored; its ack stays 0 until it is granted.
- err clears only on rst.
- rst in any state: IDLE immediately; all handshake outputs drop the next cycle. A slave mid-handshake sees link_req fall.

## Timing
- Reset values: state IDLE, gnt=00, link_req=0, link_data=0, m0_ack=m1_ack=0, cnt0=cnt1=0, err=0, last_id=1 (requester 0 wins the first tie), timer=0, seen_ack=0.
- Grant latency: m_req high at edge k → gnt, link_req, link_data valid after edge k (cycle k+1).
- Ack forwarding: link_ack→m_ack has zero cycles of latency (combinational).
- Release: the IDLE entry edge also updates the count. The arbiter spends at least one cycle in IDLE between grants.
- Back-to-back: a new grant is issued at the edge after IDLE entry, so the minimum grant-to-grant spacing is transaction length + 1 cycle.
- Simultaneous requests alternate strictly: 0,1,0,1…
- A req arriving during BUSY waits, never preempts.

## Structure
- Shared package link_pkg: state enum {IDLE, BUSY} and the DATA_W default, shared with master_fsm/slave_fsm.
- No sub-module needed. The round-robin pick and the timeout counter are inline, about 150 lines total.
- The link_top-level integration instantiates two masters, this arbiter and one slave_fsm.

## Test plan
- Single requester: m0 sends 0xA5; the slave acks after 2 cycles. Expect gnt=01, link_data=0xA5, m0_ack mirrors link_ack, return to IDLE, cnt0=1, cnt1=0.
- Tie: m0 and m1 raise req on the same cycle with 0x11/0x22. Expect order m0, then m1. Between grants, gnt=00 for exactly one cycle. Final cnt0=cnt1=1.
- Fairness: both hold req for 6 back-to-back transfers. Expect the grant sequence 0,1,0,1,0,1 and m1_ack=0 throughout every m0 grant.
- Timeout: TO_CYCLES=4, slave never acks. After 4 BUSY cycles: err=1, gnt=00, counts unchanged. err stays 1 through later good transfers until rst.
- Abort and reset: m1 drops req before any ack, so expect IDLE and cnt1 unchanged. In a second case, assert rst while link_ack=1. The next cycle expects link_req=0, both acks 0, cnts 0 and the reset tie-break favouring m0.
- Wrap: 256 transfers on m0. Expect cnt0 to wrap to 0.
